// File: rtl/pc_sequencer_if.sv
// Fetch-side bus bundle of the PC sequencer: PC adder link, instruction
// memory request/ack, decode valid/ready, redirect/halt controls and debug.
interface pc_sequencer_if;
  logic [31:0] addrPC;
  logic [31:0] outSUM;
  logic        fetch_req;
  logic        fetch_ack;
  logic [31:0] instr_in;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic        resume;
  logic        fetch_err;
  logic [2:0]  state;

  // The sequencer side: owns the PC, the fetch request and the decode output.
  modport master (
    output addrPC, fetch_req, instr_out, instr_valid, fetch_err, state,
    input  outSUM, fetch_ack, instr_in, instr_ready, branch_taken,
           branch_target, halt_req, resume
  );

  // The surrounding CPU side: PC adder, instruction memory and decode.
  modport slave (
    input  addrPC, fetch_req, instr_out, instr_valid, fetch_err, state,
    output outSUM, fetch_ack, instr_in, instr_ready, branch_taken,
           branch_target, halt_req, resume
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer. Walks each fetch
// through IDLE/FETCH/ISSUE, picks the next PC (adder result or branch target)
// on decode accept, and supports halt/resume plus sticky fetch faults.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic             clk,
  input logic             rst_n,
  pc_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  // Counter value in the last FETCH cycle allowed before declaring a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic        accept;

  // Outputs are pure decodes of registered state, so no input reaches them
  // combinationally.
  assign bus.addrPC      = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.fetch_err   = err_q;
  assign bus.state       = state_q;
  assign bus.fetch_req   = (state_q == S_FETCH);
  assign bus.instr_valid = (state_q == S_ISSUE);

  assign accept = (state_q == S_ISSUE) && bus.instr_ready;

  // Next-state logic: fetch handshake, timeout, PC selection on accept.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.fetch_ack) begin
          instr_d = bus.instr_in;
          wait_d  = 8'd0;
          state_d = S_ISSUE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
            // Misaligned redirect: keep the PC so the faulting site is visible.
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            pc_d    = bus.branch_taken ? bus.branch_target : bus.outSUM;
            state_d = bus.halt_req ? S_HALTED : S_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (bus.resume) state_d = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule
